// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: per-channel state encoding and
// the duty full-scale helper.
package led_fade_pkg;

  // Per-channel ramp state.
  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } fade_state_e;

  // Full-scale duty value (2^bits - 1) for a PWM of the given width.
  function automatic int unsigned duty_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED fade channel: ramps its duty register toward the target level one
// LSB per shared step, and compares that duty against the shared PWM counter.
//   sys_clk, rst_n : clock, async active-low reset
//   enable         : 0 forces OFF with duty 0
//   step           : one-cycle duty-step strobe, coincides with a PWM period end
//   pwm_cnt        : shared PWM counter
//   led_in         : target level for this channel
//   cmp_c          : unregistered PWM compare bit
//   ramping_c      : unregistered, next-state-is-ramping flag
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                step,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                led_in,
  output logic                cmp_c,
  output logic                ramping_c
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));

  fade_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  // Next state and duty: direction change first, then the step in the new direction.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (!enable) begin
      state_d = ST_OFF;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_OFF:       if (led_in)  state_d = ST_RAMP_UP;
        ST_RAMP_UP:   if (!led_in) state_d = ST_RAMP_DOWN;
        ST_ON:        if (!led_in) state_d = ST_RAMP_DOWN;
        ST_RAMP_DOWN: if (led_in)  state_d = ST_RAMP_UP;
        default:      state_d = ST_OFF;
      endcase
      if (step) begin
        if (state_d == ST_RAMP_UP) begin
          if (duty_q != DUTY_MAX) duty_d = duty_q + PWM_BITS'(1);
          if (duty_d == DUTY_MAX) state_d = ST_ON;
        end else if (state_d == ST_RAMP_DOWN) begin
          if (duty_q != '0) duty_d = duty_q - PWM_BITS'(1);
          if (duty_d == '0) state_d = ST_OFF;
        end
      end
    end
  end

  // State and duty registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // Full-scale duty forces the output solidly on; duty 0 never matches.
  assign cmp_c = (duty_q == DUTY_MAX) | (pwm_cnt < duty_q);

  // Taken from the next state so the registered busy lines up with state_q.
  assign ramping_c = (state_d == ST_RAMP_UP) | (state_d == ST_RAMP_DOWN);

endmodule

// File: rtl/led_fade_drv.sv
// LED fade driver: turns each on/off level of led_in into a linear PWM
// brightness ramp on led_out, using one timebase shared by all channels.
//   sys_clk, rst_n : 200 MHz system clock, async active-low reset
//   enable         : 1 = run; 0 = clear timebase, blank outputs, reset channels
//   led_in         : per-channel target levels (sys_clk domain)
//   led_out        : registered PWM drive to the LED pins
//   busy           : registered, high while any channel is ramping
module led_fade_drv
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned PWM_PRESC = 782,
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned NUM_LED   = 4
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_LED-1:0] led_in,
  output logic [NUM_LED-1:0] led_out,
  output logic               busy
);

  localparam int unsigned PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam int unsigned STEP_W  = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

  localparam logic [PWM_BITS-1:0] PWM_MAX    = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PWM_PRESC - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(RAMP_STEP - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [NUM_LED-1:0]  led_out_q, led_out_d;
  logic                busy_q, busy_d;

  logic               tick;
  logic               period_end;
  logic               step;
  logic [NUM_LED-1:0] cmp_c;
  logic [NUM_LED-1:0] ramping_c;

  // Shared timebase: prescaler -> PWM counter -> duty-step counter.
  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    period_end = tick && (pwm_cnt_q == PWM_MAX);
    step       = period_end && (step_cnt_q == STEP_LAST);

    presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
    pwm_cnt_d  = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    step_cnt_d = step_cnt_q;
    if (period_end) step_cnt_d = step ? '0 : step_cnt_q + STEP_W'(1);

    if (!enable) begin
      presc_d    = '0;
      pwm_cnt_d  = '0;
      step_cnt_d = '0;
    end

    led_out_d = enable ? cmp_c : '0;
    busy_d    = |ramping_c;
  end

  // Timebase and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      led_out_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_out_q  <= led_out_d;
      busy_q     <= busy_d;
    end
  end

  // One fade channel per LED.
  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    led_fade_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .step      (step),
      .pwm_cnt   (pwm_cnt_q),
      .led_in    (led_in[i]),
      .cmp_c     (cmp_c[i]),
      .ramping_c (ramping_c[i])
    );
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule
